// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder16bit among NUM_REQ requesters.
// The sum lands in a one-entry registered slot drained by a valid/ready handshake.

module adder16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    // Carry out is intentionally dropped; sums wrap modulo 2^WIDTH.
    assign sum = a + b;
endmodule

module adder_share_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned WIDTH   = 16,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_sum,
    output logic [ID_W-1:0]          resp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_found;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               accept;
    logic               xfer;
    logic [WIDTH-1:0]   mux_a;
    logic [WIDTH-1:0]   mux_b;
    logic [WIDTH-1:0]   sum;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_oh    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
        if (gnt_found) begin
            gnt_oh[gnt_id] = 1'b1;
        end
    end

    // One-hot operand mux; zero when nobody is granted.
    always_comb begin
        mux_a = '0;
        mux_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                mux_a = mux_a | req_a[i*WIDTH +: WIDTH];
                mux_b = mux_b | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    adder16bit #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a  (mux_a),
        .b  (mux_b),
        .sum(sum)
    );

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and round-robin pointer update.
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        case (state)
            EMPTY: if (xfer) state_next = FULL;
            FULL:  if (!xfer && resp_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        if (xfer) begin
            rr_ptr_next = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    // Handshake outputs; nothing is granted while reset is asserted.
    always_comb begin
        accept    = (state == EMPTY) || resp_ready;
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready = gnt_oh;
        end
        xfer = rst_n && accept && gnt_found;
    end

    assign resp_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            resp_sum <= '0;
            resp_id  <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
            if (xfer) begin
                resp_sum <= sum;
                resp_id  <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level round-robin model.

module tb_adder_share_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 16;
    localparam int unsigned ID_W = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [W-1:0]     resp_sum;
    logic [ID_W-1:0]  resp_id;

    adder_share_arbiter #(
        .NUM_REQ(N),
        .WIDTH  (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_sum  (resp_sum),
        .resp_id   (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit         m_valid = 0;
    logic [W-1:0] m_sum = '0;
    int         m_id  = 0;
    int         m_ptr = 0;
    int         last_xfer = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic int find_grant();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 0;
        m_sum   = '0;
        m_id    = 0;
        m_ptr   = 0;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        int           g;
        bit           acc;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        acc = !m_valid || resp_ready;
        g   = find_grant();
        exp_rdy = '0;
        if (rst_n && acc && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(m_valid));
        check("resp_sum", 32'(resp_sum), 32'(m_sum));
        check("resp_id", 32'(resp_id), 32'(m_id));
        @(posedge clk);
        last_xfer = -1;
        if (!rst_n) begin
            model_reset();
        end else if (acc && g >= 0) begin
            m_sum     = W'(32'(req_a[g*W +: W]) + 32'(req_b[g*W +: W]));
            m_id      = g;
            m_valid   = 1;
            m_ptr     = (g + 1) % N;
            last_xfer = g;
        end else if (m_valid && resp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    int           exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    bit [N-1:0]   held;
    logic [W-1:0] saved_sum;
    logic [ID_W-1:0] saved_id;

    initial begin
        rst_n      = 1'b0;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        model_reset();

        // Reset held with every requester asking
        for (int i = 0; i < N; i++) set_req(i, W'(16'h0100 + i), W'(16'h0010));
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_req_ready", 32'(req_ready), 32'h0);
        end
        rst_n = 1'b1;

        // Single request from requester 1
        req_valid = 4'b0010;
        set_req(1, 16'h1234, 16'h0001);
        #2;
        check("single_ready", 32'(req_ready), 32'h2);
        step();
        check("single_valid", 32'(resp_valid), 32'h1);
        check("single_sum", 32'(resp_sum), 32'h1235);
        check("single_id", 32'(resp_id), 32'h1);

        // Asynchronous reset drop while the slot is full
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(resp_valid), 32'h0);
        check("async_rst_sum", 32'(resp_sum), 32'h0);
        model_reset();
        step();
        rst_n = 1'b1;

        // Round-robin from reset with everyone valid
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_id", 32'(resp_id), 32'(exp_seq[i]));
            check("rr_valid", 32'(resp_valid), 32'h1);
        end

        // Wrap-around sums
        req_valid = 4'b0100;
        set_req(2, 16'hFFFF, 16'h0002);
        step();
        check("wrap_sum1", 32'(resp_sum), 32'h0001);
        set_req(2, 16'h8000, 16'h8000);
        step();
        check("wrap_sum2", 32'(resp_sum), 32'h0000);

        // Backpressure: stall 4 cycles with requests pending
        req_valid = 4'b0001;
        set_req(0, 16'h0A0A, 16'h0101);
        step();
        saved_sum  = resp_sum;
        saved_id   = resp_id;
        resp_ready = 1'b0;
        req_valid  = '1;
        for (int i = 0; i < N; i++) set_req(i, W'(16'h2000 + i), W'(16'h0003));
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_ready", 32'(req_ready), 32'h0);
            check("stall_sum", 32'(resp_sum), 32'(saved_sum));
            check("stall_id", 32'(resp_id), 32'(saved_id));
            check("stall_valid", 32'(resp_valid), 32'h1);
        end
        resp_ready = 1'b1;
        step();
        check("refill_valid", 32'(resp_valid), 32'h1);
        check("refill_id", 32'(resp_id), 32'h1);
        check("refill_sum", 32'(resp_sum), 32'h2004);

        // Pointer wrap after granting requester 3
        req_valid = 4'b1000;
        step();
        check("ptr_id3", 32'(resp_id), 32'h3);
        req_valid = 4'b0101;
        step();
        check("ptr_id0", 32'(resp_id), 32'h0);
        step();
        check("ptr_id2", 32'(resp_id), 32'h2);

        // Random traffic obeying the requester hold rule
        req_valid = '0;
        held      = '0;
        step();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (held[i] && last_xfer == i) held[i] = 1'b0;
                if (!held[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    set_req(i, ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom),
                               W'($urandom));
                    held[i] = req_valid[i];
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
